// File: rtl/time_counter_pkg.sv
// Shared definitions for the hh:mm:ss BCD time-of-day counter.
// Contents: seven-segment glyphs (bit order {g,f,e,d,c,b,a}, active-high),
// field widths, BCD field limits, and BCD helper functions used by the top.
package time_counter_pkg;

    localparam int BCD_W  = 4;
    localparam int TIME_W = 24;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [7:0] SS_MAX   = 8'h59;
    localparam logic [7:0] MM_MAX   = 8'h59;
    localparam logic [7:0] HH24_MAX = 8'h23;
    localparam logic [7:0] HH12_MIN = 8'h01;
    localparam logic [7:0] HH12_MAX = 8'h12;

    // Two-digit BCD increment; callers handle the field wrap themselves.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // True when every nibble is a decimal digit and each field is in range
    // for the given hour mode. The nibble check must come first: a value such
    // as 8'h0A would otherwise pass the plain magnitude compare against 8'h59.
    function automatic logic time_valid(input logic [23:0] t, input logic m12);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ok = ok & (t[i*4 +: 4] <= 4'd9);
        end
        ok = ok & (t[7:0] <= SS_MAX) & (t[15:8] <= MM_MAX);
        if (m12) begin
            ok = ok & (t[23:16] >= HH12_MIN) & (t[23:16] <= HH12_MAX);
        end else begin
            ok = ok & (t[23:16] <= HH24_MAX);
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// One-digit BCD to seven-segment decoder.
// Ports: bcd (4-bit digit in), seg (7-bit {g,f,e,d,c,b,a}, active-high).
// Non-decimal codes decode to all segments off.
module bcd_to_seg7
    import time_counter_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [6:0]       seg
);

    // Glyph lookup
    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/time_counter_hms.sv
// hh:mm:ss BCD time-of-day counter with prescaler, 12/24-hour mode,
// valid/ready time load, day-rollover pulse and six seven-segment digits.
// Ports:
//   clk, rst (async, active-low)   en: count enable   mode12: 1 = 12-hour
//   load_valid/load_ready/load_data {pm,hh,mm,ss}: time load; load_err pulse
//   tick: second pulse   day_carry: midnight pulse   pm: PM flag
//   time_bcd {hh,mm,ss}  seg: six digits, [6:0] = ss units .. [41:35] = hh tens
// Optional build macro TIME_COUNTER_ALARM_EN adds alarm_set/alarm_data/
// alarm_clr inputs and the sticky alarm output.
module time_counter_hms
    import time_counter_pkg::*;
#(
    parameter int CLK_DIV = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        mode12,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [24:0] load_data,
    output logic        load_err,
    output logic        tick,
    output logic        day_carry,
    output logic        pm,
    output logic [23:0] time_bcd,
    output logic [41:0] seg
`ifdef TIME_COUNTER_ALARM_EN
    ,
    input  logic        alarm_set,
    input  logic [24:0] alarm_data,
    input  logic        alarm_clr,
    output logic        alarm
`endif
);

    localparam int             DIV_W    = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    // One-second advance of {carry, pm, hh, mm, ss} in the given hour mode.
    function automatic logic [25:0] advance(input logic [23:0] t, input logic p,
                                            input logic m12);
        logic [7:0] hh, mm, ss;
        logic       np, dc;
        hh = t[23:16];
        mm = t[15:8];
        ss = t[7:0];
        np = p;
        dc = 1'b0;
        if (ss == SS_MAX) begin
            ss = 8'h00;
            if (mm == MM_MAX) begin
                mm = 8'h00;
                if (m12) begin
                    if (hh == 8'h11) begin
                        // 11 -> 12 flips AM/PM; leaving PM is the day boundary
                        hh = 8'h12;
                        np = ~p;
                        dc = p;
                    end else if (hh == HH12_MAX) begin
                        hh = 8'h01;
                    end else begin
                        hh = bcd_inc(hh);
                    end
                end else begin
                    if (hh == HH24_MAX) begin
                        hh = 8'h00;
                        dc = 1'b1;
                    end else begin
                        hh = bcd_inc(hh);
                    end
                end
            end else begin
                mm = bcd_inc(mm);
            end
        end else begin
            ss = bcd_inc(ss);
        end
        return {dc, np, hh, mm, ss};
    endfunction

    // Binary 0..23 to two-digit BCD.
    function automatic logic [7:0] bin_to_bcd(input logic [4:0] b);
        logic [7:0] r;
        if (b >= 5'd20) begin
            r = {4'd2, 4'(b - 5'd20)};
        end else if (b >= 5'd10) begin
            r = {4'd1, 4'(b - 5'd10)};
        end else begin
            r = {4'd0, b[3:0]};
        end
        return r;
    endfunction

    // Hour conversion between modes, returns {pm, hh}.
    function automatic logic [8:0] convert_hours(input logic [7:0] hh, input logic p,
                                                 input logic to12);
        logic [4:0] hb;
        logic       np;
        hb = 5'(hh[7:4]) * 5'd10 + 5'(hh[3:0]);
        if (to12) begin
            if (hb == 5'd0) begin
                hb = 5'd12;
                np = 1'b0;
            end else if (hb < 5'd12) begin
                np = 1'b0;
            end else if (hb == 5'd12) begin
                np = 1'b1;
            end else begin
                hb = hb - 5'd12;
                np = 1'b1;
            end
        end else begin
            np = 1'b0;
            if (p) begin
                hb = (hb == 5'd12) ? 5'd12 : hb + 5'd12;
            end else begin
                hb = (hb == 5'd12) ? 5'd0 : hb;
            end
        end
        return {np, bin_to_bcd(hb)};
    endfunction

    logic [DIV_W-1:0]  presc_r, presc_nx_s;
    logic [TIME_W-1:0] time_r, adv_time_s, cv_time_s, next_time_s;
    logic              pm_r, adv_pm_s, cv_pm_s, next_pm_s;
    logic              mode_r;
    logic              load_ready_r, tick_r, day_carry_r, load_err_r;
    logic [25:0]       step_s;
    logic [8:0]        conv_s;
    logic              wrap_s, accept_s, load_ok_s, do_adv_s;
    logic [41:0]       raw_seg_s;
    logic              hh_blank_s;

    // Next-state: tick advance in the stored mode, then mode conversion, then load override
    always_comb begin
        step_s    = advance(time_r, pm_r, mode_r);
        wrap_s    = en & (presc_r == DIV_LAST);
        accept_s  = load_valid & load_ready_r;
        load_ok_s = time_valid(load_data[23:0], mode12);
        // Any accepted load request (good or bad) swallows a coinciding tick.
        do_adv_s  = wrap_s & ~accept_s;

        if (do_adv_s) begin
            adv_time_s = step_s[23:0];
            adv_pm_s   = step_s[24];
        end else begin
            adv_time_s = time_r;
            adv_pm_s   = pm_r;
        end

        conv_s = convert_hours(adv_time_s[23:16], adv_pm_s, mode12);
        if (mode12 != mode_r) begin
            cv_time_s = {conv_s[7:0], adv_time_s[15:0]};
            cv_pm_s   = conv_s[8];
        end else begin
            cv_time_s = adv_time_s;
            cv_pm_s   = adv_pm_s;
        end

        if (accept_s && load_ok_s) begin
            next_time_s = load_data[23:0];
            next_pm_s   = mode12 & load_data[24];
            presc_nx_s  = '0;
        end else begin
            next_time_s = cv_time_s;
            next_pm_s   = cv_pm_s;
            if (wrap_s) begin
                presc_nx_s = '0;
            end else if (en) begin
                presc_nx_s = presc_r + DIV_W'(1);
            end else begin
                presc_nx_s = presc_r;
            end
        end
    end

    // State and registered outputs; reset time depends on mode12 at reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_r      <= '0;
            time_r       <= {(mode12 ? 8'h12 : 8'h00), 16'h0000};
            pm_r         <= 1'b0;
            mode_r       <= mode12;
            load_ready_r <= 1'b0;
            tick_r       <= 1'b0;
            day_carry_r  <= 1'b0;
            load_err_r   <= 1'b0;
        end else begin
            presc_r      <= presc_nx_s;
            time_r       <= next_time_s;
            pm_r         <= next_pm_s;
            mode_r       <= mode12;
            load_ready_r <= 1'b1;
            tick_r       <= do_adv_s;
            day_carry_r  <= do_adv_s & step_s[25];
            load_err_r   <= accept_s & ~load_ok_s;
        end
    end

    for (genvar gi = 0; gi < 6; gi++) begin : g_digit
        bcd_to_seg7 u_dec (
            .bcd (time_r[gi*BCD_W +: BCD_W]),
            .seg (raw_seg_s[gi*7 +: 7])
        );
    end

    // mode_r tracks the mode the stored time is expressed in
    assign hh_blank_s = mode_r & (time_r[23:20] == 4'd0);
    assign seg        = {(hh_blank_s ? SEG_BLANK : raw_seg_s[41:35]), raw_seg_s[34:0]};

    assign load_ready = load_ready_r;
    assign load_err   = load_err_r;
    assign tick       = tick_r;
    assign day_carry  = day_carry_r;
    assign pm         = pm_r;
    assign time_bcd   = time_r;

`ifdef TIME_COUNTER_ALARM_EN
    logic [24:0] alarm_reg_r;
    logic        alarm_r;
    logic        alarm_hit_s;

    // Only a real second advance can match, so a load never raises the alarm
    assign alarm_hit_s = do_adv_s & ({next_pm_s, next_time_s} == alarm_reg_r);

    // Alarm compare register (all-ones never matches) and sticky alarm flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alarm_reg_r <= {25{1'b1}};
            alarm_r     <= 1'b0;
        end else begin
            if (alarm_set) begin
                alarm_reg_r <= alarm_data;
            end else begin
                alarm_reg_r <= alarm_reg_r;
            end
            if (alarm_clr) begin
                alarm_r <= 1'b0;
            end else if (alarm_hit_s) begin
                alarm_r <= 1'b1;
            end else begin
                alarm_r <= alarm_r;
            end
        end
    end

    assign alarm = alarm_r;
`endif

endmodule
